// File: rtl/alp_slice_wide.sv
// alp_slice_wide: WIDTH-bit ALP arithmetic/logic processor with Q register,
// registered W result and flags, plus shift-and-add multiply and restoring
// divide sequencers behind a start/busy/done handshake.
// Build option: define ALP_DIV_EN to include the divide sequencer; without it
// opcode 10 is an illegal-op NOP that sets V.
module alp_slice_wide #(
  parameter int WIDTH = 16
) (
  input  logic             qdck_l,
  input  logic             reset_h,
  input  logic [WIDTH-1:0] rbus_h,
  input  logic [WIDTH-1:0] mbus_h,
  input  logic [3:0]       opc_h,
  input  logic             cyin_h,
  input  logic             sin_h,
  input  logic             start_h,
  output logic [WIDTH-1:0] wbus_h,
  output logic [WIDTH-1:0] q_h,
  output logic             busy_h,
  output logic             done_h,
  output logic             z_h,
  output logic             n_h,
  output logic             c_h,
  output logic             v_h
);

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_PASSA = 4'd5,
    OP_LDQ   = 4'd6,
    OP_SHL   = 4'd7,
    OP_SHR   = 4'd8,
    OP_MUL   = 4'd9,
    OP_DIV   = 4'd10
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef ALP_DIV_EN
    , S_DIV = 2'd2
`endif
  } state_t;

  state_t           state, state_nx;
  op_t              op;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic             accept, last;

  logic [WIDTH-1:0] add_b, alu_w, alu_q;
  logic [WIDTH:0]   add_sum, mul_sum;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] mul_w, mul_q;

`ifdef ALP_DIV_EN
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   div_sh;
  logic             div_ok;
  logic [WIDTH-1:0] div_w, div_q;
`endif

  // Opcode decode
  always_comb op = op_t'(opc_h);

  // State register
  always_ff @(posedge qdck_l) begin
    if (reset_h) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state: multi-cycle ops leave IDLE, the last iteration returns
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_h) begin
          if (op == OP_MUL) state_nx = S_MUL;
`ifdef ALP_DIV_EN
          else if (op == OP_DIV && mbus_h != '0) state_nx = S_DIV;
`endif
        end
      end
      S_MUL: if (last) state_nx = S_IDLE;
`ifdef ALP_DIV_EN
      S_DIV: if (last) state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs and sequencer status
  always_comb begin
    busy_h = (state != S_IDLE);
    accept = start_h && (state == S_IDLE);
    last   = busy_h && (cnt == CW'(1));
  end

  // Single-cycle ALU result and per-iteration multiply/divide steps
  always_comb begin
    alu_w   = wbus_h;
    alu_q   = q_h;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    add_b   = (op == OP_SUB) ? ~mbus_h : mbus_h;
    add_sum = {1'b0, rbus_h} + {1'b0, add_b} + {{WIDTH{1'b0}}, cyin_h};
    case (op)
      OP_ADD, OP_SUB: begin
        alu_w = add_sum[MSB:0];
        alu_c = add_sum[WIDTH];
        alu_v = (rbus_h[MSB] == add_b[MSB]) && (add_sum[MSB] != rbus_h[MSB]);
      end
      OP_AND:   alu_w = rbus_h & mbus_h;
      OP_OR:    alu_w = rbus_h | mbus_h;
      OP_XOR:   alu_w = rbus_h ^ mbus_h;
      OP_PASSA: alu_w = rbus_h;
      OP_SHL: begin
        alu_w = {rbus_h[MSB-1:0], q_h[MSB]};
        alu_q = {q_h[MSB-1:0], sin_h};
        alu_c = rbus_h[MSB];
      end
      OP_SHR: begin
        alu_w = {sin_h, rbus_h[MSB:1]};
        alu_q = {rbus_h[0], q_h[MSB:1]};
        alu_c = q_h[0];
      end
      default: ;
    endcase

    mul_sum = {1'b0, wbus_h} + (q_h[0] ? {1'b0, mcand} : '0);
    mul_w   = mul_sum[WIDTH:1];
    mul_q   = {mul_sum[0], q_h[MSB:1]};

`ifdef ALP_DIV_EN
    // Partial remainder is WIDTH+1 bits after the shift; when it fits the
    // divisor the true difference is below 2**WIDTH, so WIDTH bits suffice.
    div_sh = {wbus_h, q_h[MSB]};
    div_ok = (div_sh >= {1'b0, divisor});
    div_w  = div_ok ? (div_sh[MSB:0] - divisor) : div_sh[MSB:0];
    div_q  = {q_h[MSB-1:0], div_ok};
`endif
  end

  // Datapath registers: W, Q, flags, operand latches, counter, done pulse
  always_ff @(posedge qdck_l) begin
    if (reset_h) begin
      wbus_h <= '0;
      q_h    <= '0;
      z_h    <= 1'b0;
      n_h    <= 1'b0;
      c_h    <= 1'b0;
      v_h    <= 1'b0;
      done_h <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
`ifdef ALP_DIV_EN
      divisor <= '0;
`endif
    end else begin
      done_h <= 1'b0;
      if (accept) begin
        done_h <= 1'b1;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASSA, OP_SHL, OP_SHR: begin
            wbus_h <= alu_w;
            q_h    <= alu_q;
            z_h    <= (alu_w == '0);
            n_h    <= alu_w[MSB];
            c_h    <= alu_c;
            v_h    <= alu_v;
          end
          OP_LDQ: q_h <= mbus_h;
          OP_MUL: begin
            q_h    <= mbus_h;
            wbus_h <= '0;
            mcand  <= rbus_h;
            cnt    <= CW'(WIDTH);
            done_h <= 1'b0;
          end
          OP_DIV: begin
`ifdef ALP_DIV_EN
            if (mbus_h == '0) begin
              q_h    <= '1;
              wbus_h <= rbus_h;
              z_h    <= 1'b0;
              n_h    <= 1'b0;
              c_h    <= 1'b0;
              v_h    <= 1'b1;
            end else begin
              q_h     <= rbus_h;
              wbus_h  <= '0;
              divisor <= mbus_h;
              cnt     <= CW'(WIDTH);
              done_h  <= 1'b0;
            end
`else
            v_h <= 1'b1;
`endif
          end
          default: ;
        endcase
      end else if (state == S_MUL) begin
        wbus_h <= mul_w;
        q_h    <= mul_q;
        cnt    <= cnt - CW'(1);
        if (last) begin
          done_h <= 1'b1;
          z_h    <= (mul_w == '0) && (mul_q == '0);
          n_h    <= mul_w[MSB];
          c_h    <= 1'b0;
          v_h    <= 1'b0;
        end
      end
`ifdef ALP_DIV_EN
      else if (state == S_DIV) begin
        wbus_h <= div_w;
        q_h    <= div_q;
        cnt    <= cnt - CW'(1);
        if (last) begin
          done_h <= 1'b1;
          z_h    <= (div_q == '0);
          n_h    <= 1'b0;
          c_h    <= 1'b0;
          v_h    <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alp_slice_wide.sv
// tb_alp_slice_wide: randomized self-checking bench for alp_slice_wide
// (WIDTH=16) against an arithmetic reference model.
module tb_alp_slice_wide;

  logic        clk = 1'b0;
  logic        reset_h;
  logic [15:0] rbus_h, mbus_h;
  logic [3:0]  opc_h;
  logic        cyin_h, sin_h, start_h;
  logic [15:0] wbus_h, q_h;
  logic        busy_h, done_h, z_h, n_h, c_h, v_h;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] mw, mq;
  logic        mz, mn, mc, mv;

  alp_slice_wide #(.WIDTH(16)) dut (
    .qdck_l (clk),
    .reset_h(reset_h),
    .rbus_h (rbus_h),
    .mbus_h (mbus_h),
    .opc_h  (opc_h),
    .cyin_h (cyin_h),
    .sin_h  (sin_h),
    .start_h(start_h),
    .wbus_h (wbus_h),
    .q_h    (q_h),
    .busy_h (busy_h),
    .done_h (done_h),
    .z_h    (z_h),
    .n_h    (n_h),
    .c_h    (c_h),
    .v_h    (v_h)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mw = '0; mq = '0; mz = 1'b0; mn = 1'b0; mc = 1'b0; mv = 1'b0;
  endtask

  // Apply one command to the model; multi=1 when it runs the 16-cycle sequencer
  task automatic model_apply(input logic [3:0] op, input logic [15:0] a, b,
                             input logic cy, sn, output bit multi);
    logic [15:0]  bb;
    int unsigned  us;
    shortint      sa, sb;
    int           ss, ci;
    logic [31:0]  t, p;
    logic [32:0]  u;
    multi = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        bb = (op == 4'd1) ? ~b : b;
        us = 32'(a) + 32'(bb) + 32'(cy);
        sa = a; sb = bb; ci = int'(cy);
        ss = int'(sa) + int'(sb) + ci;
        mw = us[15:0];
        mc = (us > 32'hFFFF);
        mv = (ss > 32767) || (ss < -32768);
      end
      4'd2: begin mw = a & b; mc = 1'b0; mv = 1'b0; end
      4'd3: begin mw = a | b; mc = 1'b0; mv = 1'b0; end
      4'd4: begin mw = a ^ b; mc = 1'b0; mv = 1'b0; end
      4'd5: begin mw = a;     mc = 1'b0; mv = 1'b0; end
      4'd6: mq = b;
      4'd7: begin
        t  = ({a, mq} << 1) | 32'(sn);
        mc = a[15];
        mw = t[31:16]; mq = t[15:0]; mv = 1'b0;
      end
      4'd8: begin
        u  = {sn, a, mq};
        mc = mq[0];
        u  = u >> 1;
        mw = u[31:16]; mq = u[15:0]; mv = 1'b0;
      end
      4'd9: begin
        p  = 32'(a) * 32'(b);
        mw = p[31:16]; mq = p[15:0];
        mz = (p == 0); mn = mw[15]; mc = 1'b0; mv = 1'b0;
        multi = 1'b1;
      end
      4'd10: begin
`ifdef ALP_DIV_EN
        if (b == 0) begin
          mq = 16'hFFFF; mw = a; mz = 1'b0; mn = 1'b0; mc = 1'b0; mv = 1'b1;
        end else begin
          mq = a / b; mw = a % b;
          mz = (mq == 0); mn = 1'b0; mc = 1'b0; mv = 1'b0;
          multi = 1'b1;
        end
`else
        mv = 1'b1;
`endif
      end
      default: ;
    endcase
    if (op <= 4'd5 || op == 4'd7 || op == 4'd8) begin
      mz = (mw == 0);
      mn = mw[15];
    end
  endtask

  // Issue a command at the current negedge, wait for done, compare with model.
  // pulse_chk: also verify done drops next cycle. poke: random start/operand
  // noise on every busy cycle (must be ignored).
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, b,
                        input logic cy, sn, input bit pulse_chk, input bit poke);
    int busy_n;
    int t;
    bit multi;
    opc_h = op; rbus_h = a; mbus_h = b; cyin_h = cy; sin_h = sn; start_h = 1'b1;
    model_apply(op, a, b, cy, sn, multi);
    @(negedge clk);
    start_h = 1'b0;
    busy_n = 0;
    t = 0;
    while (!done_h && t < 40) begin
      if (busy_h) busy_n++;
      if (poke) begin
        start_h = 1'($urandom_range(0, 1));
        opc_h   = 4'($urandom);
        rbus_h  = 16'($urandom);
        mbus_h  = 16'($urandom);
        cyin_h  = 1'($urandom);
        sin_h   = 1'($urandom);
      end
      @(negedge clk);
      t++;
    end
    start_h = 1'b0;
    check($sformatf("done op%0d", op), 64'(done_h), 64'd1);
    check($sformatf("busy_len op%0d", op), 64'(busy_n), multi ? 64'd16 : 64'd0);
    check($sformatf("busy_at_done op%0d", op), 64'(busy_h), 64'd0);
    check($sformatf("wbus op%0d", op), 64'(wbus_h), 64'(mw));
    check($sformatf("q op%0d", op), 64'(q_h), 64'(mq));
    check($sformatf("flags_znCV op%0d", op), 64'({z_h, n_h, c_h, v_h}), 64'({mz, mn, mc, mv}));
    if (pulse_chk) begin
      @(negedge clk);
      check($sformatf("done_pulse op%0d", op), 64'(done_h), 64'd0);
    end
  endtask

  initial begin
    int dones;
    logic [3:0]  rop;
    logic [15:0] ra, rb;

    reset_h = 1'b1; start_h = 1'b0; opc_h = '0; rbus_h = '0; mbus_h = '0;
    cyin_h = 1'b0; sin_h = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", 64'({wbus_h, q_h, busy_h, done_h, z_h, n_h, c_h, v_h}), 64'd0);
    reset_h = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);   // ADD overflow
    run_op(4'd1, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0);   // SUB to zero
    run_op(4'd6, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);   // LDQ
    run_op(4'd7, 16'h8001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);   // SHL
    run_op(4'd8, 16'h1235, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);   // SHR
    run_op(4'd9, 16'h1234, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0);   // MUL
    run_op(4'd9, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);   // MUL max, poked
    run_op(4'd10, 16'd100, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0);      // DIV
    run_op(4'd10, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);  // DIV by zero
    run_op(4'd12, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0);  // NOP

    // Abort: ignored start at busy cycle 3, reset at busy cycle 5
    opc_h = 4'd9; rbus_h = 16'h1234; mbus_h = 16'h0010; start_h = 1'b1;
    @(negedge clk); start_h = 1'b0;
    check("abort_busy1", 64'(busy_h), 64'd1);
    @(negedge clk);
    @(negedge clk);
    opc_h = 4'd0; rbus_h = 16'h1111; mbus_h = 16'h2222; start_h = 1'b1;
    @(negedge clk); start_h = 1'b0;
    @(negedge clk);
    check("abort_busy5", 64'(busy_h), 64'd1);
    reset_h = 1'b1;
    @(negedge clk); reset_h = 1'b0;
    check("abort_reset_state", 64'({wbus_h, q_h, busy_h, done_h, z_h, n_h, c_h, v_h}), 64'd0);
    model_reset();
    dones = 0;
    repeat (20) begin
      if (done_h || busy_h) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_op(4'd0, 16'h0102, 16'h0304, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back: MUL started in the LDQ done cycle uses its own B
    run_op(4'd6, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'd9, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized commands
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 9) == 0) ra = '0;
      run_op(rop, ra, rb, 1'($urandom), 1'($urandom),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alp_slice_wide.md
Name: alp_slice_wide

Overview:
- Parametrised successor to the 4-bit ALP bit-slice, for the data path processor (DPM).
- Single WIDTH-bit arithmetic/logic processor with:
  - an internal Q register,
  - a registered W (write bus) result,
  - registered flags,
  - a multi-cycle shift-and-add multiply sequencer and a restoring divide sequencer.
- Replaces cascaded 4-bit slices plus external multiply/divide microcode loops with one start/busy/done handshake block.

Parameters:
- WIDTH, 16, datapath width in bits; legal values are 4 to 64 in multiples of 4. The iteration counter width is derived as clog2(WIDTH)+1.

Ports:
- qdck_l  in  1  clock; all state updates on the rising edge of qdck_l.
- reset_h  in  1  synchronous active-high reset.
- rbus_h  in  WIDTH  operand A (rotator bus).
- mbus_h  in  WIDTH  operand B (memory bus).
- opc_h  in  4  opcode, sampled with start_h.
- cyin_h  in  1  carry in, sampled with start_h.
- sin_h  in  1  serial shift-in bit for SHL/SHR.
- start_h  in  1  command strobe.
- wbus_h  out  WIDTH  registered result (W register).
- q_h  out  WIDTH  Q register.
- busy_h  out  1  multi-cycle operation in progress.
- done_h  out  1  one-cycle completion pulse.
- z_h, n_h, c_h, v_h  out  1 each  registered flags.

Behaviour:
- Reset: reset is synchronous; all outputs, the iteration counter and the sequencer state are cleared to 0.
  - Reset wins over start_h in the same cycle.
  - Reset during MUL/DIV aborts the operation; no done_h is produced.
- States: IDLE, MUL, DIV.
  - start_h is accepted only in IDLE.
  - start_h while busy_h=1 is ignored, with no side effects.
- Single-cycle ops (IDLE to IDLE): results are registered on the accepting edge; done_h=1 for the following cycle; busy_h stays 0.
  - 0 ADD: W=A+B+cyin.
  - 1 SUB: W=A+~B+cyin (cyin=1 gives a true subtract); C=carry out, i.e. no borrow.
  - 2 AND, 3 OR, 4 XOR, 5 PASSA: W=A.
  - 6 LDQ: Q=B; W and flags unchanged.
  - 7 SHL: {W,Q}={A,Q}<<1 with Q[0]=sin_h; C=A[MSB].
  - 8 SHR: {W,Q}={A,Q}>>1 with W[MSB]=sin_h; C=Q[0].
  - 11-15: NOP. done_h pulses; W, Q and flags are unchanged.
- Flags on single-cycle ops:
  - Z=(W==0), N=W[MSB].
  - For ADD/SUB: C is the carry out and V is signed overflow of the WIDTH-bit result.
  - For logic ops and PASSA: C=0, V=0.
  - For shifts: V=0.
- 9 MUL (unsigned):
  - On the accepting edge: Q=B (multiplier), W=0, the multiplicand is latched from A, and the counter is loaded with WIDTH.
  - busy_h=1 from the next cycle.
  - Each edge adds the multiplicand to W if Q[0]=1, then shifts {carry,W,Q} right by one.
  - After WIDTH iterations: W=high half, Q=low half, busy_h=0, done_h=1 for one cycle. Total is WIDTH+1 edges from start to the done cycle.
  - Flags: Z=({W,Q}==0), N=W[MSB], C=0, V=0.
- 10 DIV (unsigned restoring):
  - Dividend is A, divisor is B.
  - On the accepting edge: Q=A, W=0, the divisor is latched.
  - Each edge shifts {W,Q} left, then attempts W-divisor. If there is no borrow, W takes the difference and Q[0]=1; otherwise Q[0]=0.
  - After WIDTH iterations: Q=quotient, W=remainder. Timing is the same as MUL.
  - Flags: Z=(Q==0), N=0, C=0, V=0.
- DIV with B==0: no iterations are run.
  - Q=all ones, W=A, V=1, Z=0, C=0, N=0.
  - done_h pulses in the cycle after acceptance, as for a single-cycle op; busy_h stays 0.
- Back-to-back: start_h may be reasserted in the same cycle done_h is high; it is accepted, since the sequencer is already in IDLE.
- wbus_h, q_h and the flags hold their values between operations. During MUL/DIV they show intermediate values, which are valid only once done_h=1.

Optional Feature:
- ALP_DIV_EN:
  - Defined: opcode 10 behaves as DIV above.
  - Undefined: the DIV state and divisor latch are not built. Opcode 10 is treated as NOP except that V=1, flagging an illegal op, with a single-cycle done_h.

Test Plan:
- WIDTH=16, ADD A=0x7FFF B=0x0001 cyin=0: W=0x8000, N=1, V=1, C=0, Z=0; done_h one cycle after start, busy_h never set.
- SUB A=0x0005 B=0x0005 cyin=1: W=0x0000, Z=1, C=1, V=0. Then SHL A=0x8001 Q=0x8000 sin=1: W=0x0003, Q=0x0001, C=1.
- MUL A=0x1234 B=0x0010: busy_h high for exactly 16 cycles; then W=0x0001, Q=0x2340, done_h a single pulse, Z=0.
- DIV A=100 B=7: Q=14, W=2 after 16 busy cycles. DIV A=0x1234 B=0: V=1, Q=0xFFFF, W=0x1234, done_h after 1 cycle, busy_h=0. Without ALP_DIV_EN: V=1, W and Q unchanged.
- Start MUL, assert start_h with ADD at busy cycle 3 (ignored), then reset_h at busy cycle 5: all outputs 0 on the next edge, no done_h, next start accepted normally.
- LDQ B=0xBEEF, then MUL start in the same cycle as the LDQ done_h pulse: back-to-back acceptance; MUL uses B from its own start cycle, not the old Q.
